// File: rtl/mem_req_arbiter.sv
// Shares one RAM port between instruction fetches and data accesses.
// Data has priority, a starvation limit lets a waiting fetch through, and a timeout aborts stuck accesses.
module mem_req_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [DATA_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              bus_err,
  output logic [CNT_W-1:0]  igrant_cnt,
  output logic [CNT_W-1:0]  dgrant_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hBAD0BAD0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IACC,
    S_DREAD,
    S_DWRITE,
    S_TURN
  } state_t;

  state_t             state_q;
  logic               ram_ren_q;
  logic               ram_wen_q;
  logic [DATA_W-1:0]  ram_addr_q;
  logic [DATA_W-1:0]  ram_store_q;
  logic               bus_err_q;
  logic [CNT_W-1:0]   igrant_cnt_q;
  logic [CNT_W-1:0]   dgrant_cnt_q;
  logic [SW-1:0]      starve_q;
  logic [TW-1:0]      to_cnt_q;

  logic [CNT_W-1:0]   igrant_cnt_d;
  logic [CNT_W-1:0]   dgrant_cnt_d;
  logic [SW-1:0]      starve_d;
  logic               fetch_wins;
  logic               in_acc;
  logic               to_hit;
  logic               acc_done;
  logic               owner_req;
  logic               done_pulse;
  logic [DATA_W-1:0]  load_val;

  always_comb begin
    igrant_cnt_d = (igrant_cnt_q == '1) ? igrant_cnt_q : igrant_cnt_q + 1'b1;
    dgrant_cnt_d = (dgrant_cnt_q == '1) ? dgrant_cnt_q : dgrant_cnt_q + 1'b1;
    // A data grant only ages the starve count while a fetch is actually waiting.
    starve_d     = iREN ? starve_q + 1'b1 : '0;
    fetch_wins   = iREN && (starve_q == SW'(STARVE_LIMIT));
  end

  always_comb begin
    in_acc    = (state_q == S_IACC) || (state_q == S_DREAD) || (state_q == S_DWRITE);
    to_hit    = in_acc && !ram_ready && (to_cnt_q == TW'(TIMEOUT - 1));
    acc_done  = in_acc && (ram_ready || to_hit);
    owner_req = 1'b0;
    case (state_q)
      S_IACC:   owner_req = iREN;
      S_DREAD:  owner_req = dREN;
      S_DWRITE: owner_req = dWEN;
      default:  owner_req = 1'b0;
    endcase
    // A requester that let go mid-access gets no completion pulse.
    done_pulse = acc_done && owner_req;
    if (to_hit)
      load_val = BAD_WORD;
    else if (state_q == S_DWRITE)
      load_val = '0;
    else
      load_val = ram_load;
    iwait = !(done_pulse && (state_q == S_IACC));
    dwait = !(done_pulse && (state_q != S_IACC));
    iload = iwait ? '0 : load_val;
    dload = dwait ? '0 : load_val;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
      bus_err_q    <= 1'b0;
      igrant_cnt_q <= '0;
      dgrant_cnt_q <= '0;
      starve_q     <= '0;
      to_cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_wins || (iREN && !dWEN && !dREN)) begin
            state_q      <= S_IACC;
            ram_ren_q    <= 1'b1;
            ram_addr_q   <= iaddr;
            starve_q     <= '0;
            igrant_cnt_q <= igrant_cnt_d;
          end else if (dWEN) begin
            state_q      <= S_DWRITE;
            ram_wen_q    <= 1'b1;
            ram_addr_q   <= daddr;
            ram_store_q  <= dstore;
            starve_q     <= starve_d;
            dgrant_cnt_q <= dgrant_cnt_d;
          end else if (dREN) begin
            state_q      <= S_DREAD;
            ram_ren_q    <= 1'b1;
            ram_addr_q   <= daddr;
            starve_q     <= starve_d;
            dgrant_cnt_q <= dgrant_cnt_d;
          end
        end
        S_IACC, S_DREAD, S_DWRITE: begin
          if (acc_done) begin
            state_q   <= S_TURN;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            to_cnt_q  <= '0;
            if (to_hit)
              bus_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_TURN:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_ren    = ram_ren_q;
  assign ram_wen    = ram_wen_q;
  assign ram_addr   = ram_addr_q;
  assign ram_store  = ram_store_q;
  assign bus_err    = bus_err_q;
  assign igrant_cnt = igrant_cnt_q;
  assign dgrant_cnt = dgrant_cnt_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a small RAM responder with programmable latency and a
// completion scoreboard filled by each scenario and drained by a negedge monitor.
module tb_mem_req_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] load;
  } exp_t;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        bus_err;
  logic [1:0]  igrant_cnt;
  logic [1:0]  dgrant_cnt;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  bit          ram_on = 1'b0;
  int          ram_lat = 0;
  int          ram_age = 0;
  logic [31:0] ram_rdata = '0;

  mem_req_arbiter #(
    .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8), .CNT_W(2)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .bus_err(bus_err), .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM responder: ready ram_lat cycles after the strobe rises.
  always @(posedge CLK) begin
    if (!(ram_ren || ram_wen) || ram_ready) ram_age <= 0;
    else                                    ram_age <= ram_age + 1;
  end
  always_comb begin
    ram_ready = ram_on && (ram_ren || ram_wen) && (ram_age == ram_lat);
    ram_load  = ram_rdata;
  end

  // Completion monitor
  always @(negedge CLK) begin
    if (nRST) begin
      checks++;
      if (!iwait && !dwait) begin
        errors++;
        $display("FAIL both_waits_low: iwait=%0b dwait=%0b required not both 0", iwait, dwait);
      end
      checks++;
      if (ram_ren && ram_wen) begin
        errors++;
        $display("FAIL both_strobes: ram_ren=%0b ram_wen=%0b required not both 1", ram_ren, ram_wen);
      end
      if (!iwait || !dwait) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion: dwait=%0b iwait=%0b with empty scoreboard", dwait, iwait);
        end else begin
          exp_t e;
          exp_t got;
          e = exp_q.pop_front();
          got.is_d = !dwait;
          got.load = !dwait ? dload : iload;
          if (got !== e) begin
            errors++;
            $display("FAIL completion: got is_d=%0b load=%h required is_d=%0b load=%h",
                     got.is_d, got.load, e.is_d, e.load);
          end else begin
            $display("completion %s load=%h", got.is_d ? "data " : "fetch", got.load);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_on = 1'b0; ram_lat = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    nRST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ram_ren, ram_wen, ram_addr, ram_store} !== 66'b0) begin
      errors++;
      $display("FAIL reset_ram: ren=%0b wen=%0b addr=%h store=%h required all 0", ram_ren, ram_wen, ram_addr, ram_store);
    end
    checks++;
    if ({iwait, dwait, iload, dload, bus_err, igrant_cnt, dgrant_cnt} !== {2'b11, 64'b0, 5'b0}) begin
      errors++;
      $display("FAIL reset_outs: iwait=%0b dwait=%0b iload=%h dload=%h bus_err=%0b cnt=%0d/%0d",
               iwait, dwait, iload, dload, bus_err, igrant_cnt, dgrant_cnt);
    end
    tick();
    nRST = 1'b1;
    dREN = 1'b1; daddr = 32'h900;
    tick();
    @(negedge CLK);
    checks++;
    if (ram_ren !== 1'b1 || dgrant_cnt !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre_dread: ram_ren=%0b dgrant=%0d required 1/1", ram_ren, dgrant_cnt);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ram_ren !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1 || dgrant_cnt !== 2'd0 ||
        igrant_cnt !== 2'd0 || bus_err !== 1'b0 || ram_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ram_ren=%0b iwait=%0b dwait=%0b dgrant=%0d igrant=%0d bus_err=%0b addr=%h",
               ram_ren, iwait, dwait, dgrant_cnt, igrant_cnt, bus_err, ram_addr);
    end
    dREN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    ram_on = 1'b1; ram_lat = 2; ram_rdata = 32'h8C010004;
    iREN = 1'b1; iaddr = 32'h40;
    exp_q.push_back('{1'b0, 32'h8C010004});
    for (int c = 0; c <= 3; c++) begin
      @(negedge CLK);
      checks++;
      if (iwait !== ((c == 3) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL fetch_iwait c%0d: iwait=%0b required %0b", c, iwait, (c == 3) ? 1'b0 : 1'b1);
      end
      if (c >= 1) begin
        checks++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h40) begin
          errors++;
          $display("FAIL fetch_strobe c%0d: ram_ren=%0b addr=%h required 1/00000040", c, ram_ren, ram_addr);
        end
      end
      tick();
    end
    iREN = 1'b0;
    @(negedge CLK);
    checks++;
    if (igrant_cnt !== 2'd1 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL fetch_after: igrant=%0d ram_ren=%0b required 1/0", igrant_cnt, ram_ren);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    ram_on = 1'b1; ram_lat = 0; ram_rdata = 32'h13572468;
    iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 32'h0});
    exp_q.push_back('{1'b0, 32'h13572468});
    tick();
    @(negedge CLK);
    checks++;
    if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h100 ||
        ram_store !== 32'hDEADBEEF || dwait !== 1'b0) begin
      errors++;
      $display("FAIL contention_write: wen=%0b ren=%0b addr=%h store=%h dwait=%0b required 1/0/100/DEADBEEF/0",
               ram_wen, ram_ren, ram_addr, ram_store, dwait);
    end
    tick();
    dWEN = 1'b0;
    @(negedge CLK);
    checks++;
    if (ram_wen !== 1'b0 || ram_ren !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
      errors++;
      $display("FAIL contention_turn: wen=%0b ren=%0b iwait=%0b dwait=%0b required 0/0/1/1",
               ram_wen, ram_ren, iwait, dwait);
    end
    tick();
    tick();
    @(negedge CLK);
    checks++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h80 || iwait !== 1'b0) begin
      errors++;
      $display("FAIL contention_fetch: ren=%0b addr=%h iwait=%0b required 1/80/0", ram_ren, ram_addr, iwait);
    end
    tick();
    iREN = 1'b0;
  endtask

  task automatic test_starvation();
    int done;
    int cyc;
    apply_reset();
    ram_on = 1'b1; ram_lat = 1; ram_rdata = 32'h2468ACE0;
    iREN = 1'b1; iaddr = 32'h200;
    dREN = 1'b1; daddr = 32'h300;
    for (int k = 0; k < 10; k++)
      exp_q.push_back('{((k % 5) != 4), 32'h2468ACE0});
    done = 0;
    cyc = 0;
    while (done < 10 && cyc < 80) begin
      @(negedge CLK);
      if (!iwait || !dwait) begin
        checks++;
        if (ram_addr !== (((done % 5) != 4) ? 32'h300 : 32'h200)) begin
          errors++;
          $display("FAIL starve_grant #%0d: ram_addr=%h required %h", done, ram_addr,
                   ((done % 5) != 4) ? 32'h300 : 32'h200);
        end
        done++;
      end
      tick();
      cyc++;
    end
    iREN = 1'b0; dREN = 1'b0;
    checks++;
    if (done != 10) begin
      errors++;
      $display("FAIL starve_budget: completions=%0d required 10", done);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    ram_on = 1'b0;
    dREN = 1'b1; daddr = 32'h500;
    exp_q.push_back('{1'b1, 32'hBAD0BAD0});
    for (int c = 0; c <= 9; c++) begin
      @(negedge CLK);
      if (c <= 8) begin
        checks++;
        if (dwait !== ((c == 8) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL timeout_dwait c%0d: dwait=%0b required %0b", c, dwait, (c == 8) ? 1'b0 : 1'b1);
        end
      end
      if (c >= 8) begin
        checks++;
        if (bus_err !== ((c == 9) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL timeout_bus_err c%0d: bus_err=%0b required %0b", c, bus_err, (c == 9) ? 1'b1 : 1'b0);
        end
      end
      tick();
      if (c == 8) dREN = 1'b0;
    end
    ram_on = 1'b1; ram_lat = 0; ram_rdata = 32'h600D600D;
    dREN = 1'b1; daddr = 32'h504;
    exp_q.push_back('{1'b1, 32'h600D600D});
    tick();
    @(negedge CLK);
    checks++;
    if (dwait !== 1'b0 || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_good: dwait=%0b bus_err=%0b required 0/1", dwait, bus_err);
    end
    tick();
    dREN = 1'b0;
    tick();
    @(negedge CLK);
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: bus_err=%0b required 1", bus_err);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    ram_on = 1'b1; ram_lat = 2; ram_rdata = 32'h77777777;
    iREN = 1'b1; iaddr = 32'h700;
    tick();
    @(negedge CLK);
    checks++;
    if (ram_ren !== 1'b1) begin
      errors++;
      $display("FAIL drop_strobe: ram_ren=%0b required 1", ram_ren);
    end
    tick();
    iREN = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      checks++;
      if (iwait !== 1'b1 || ram_ren !== ((c == 4) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL drop_c%0d: iwait=%0b ram_ren=%0b required 1/%0b", c, iwait, ram_ren, (c == 4) ? 1'b0 : 1'b1);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int done;
    int cyc;
    apply_reset();
    ram_on = 1'b1; ram_lat = 0; ram_rdata = 32'h00005A5A;
    dREN = 1'b1; daddr = 32'h800;
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{1'b1, 32'h00005A5A});
    done = 0;
    cyc = 0;
    while (done < 5 && cyc < 40) begin
      @(negedge CLK);
      if (!dwait) begin
        done++;
        checks++;
        if (dgrant_cnt !== 2'((done > 3) ? 3 : done)) begin
          errors++;
          $display("FAIL sat_count #%0d: dgrant_cnt=%0d required %0d", done, dgrant_cnt, (done > 3) ? 3 : done);
        end
      end
      tick();
      cyc++;
    end
    dREN = 1'b0;
    @(negedge CLK);
    checks++;
    if (done != 5 || dgrant_cnt !== 2'd3 || igrant_cnt !== 2'd0) begin
      errors++;
      $display("FAIL sat_final: completions=%0d dgrant=%0d igrant=%0d required 5/3/0", done, dgrant_cnt, igrant_cnt);
    end
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_timeout();
    test_drop();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
